panel_page_scheduler: RTL and testbench

Double-buffer page controller between the UDP pixel writer and the panel framebuffer RAMs. Pixel writes always land in the back page. A host commit swaps front and back pages, but only at the scanner's next frame start, so the display never tears. After a swap it optionally clears the new back page by sweeping zeros through it.

---
 rtl/panel_page_scheduler_pkg.sv | 12 +
 rtl/panel_page_clear.sv | 31 +++
 rtl/panel_page_scheduler.sv | 138 +++++++++++++
 tb/tb_panel_page_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_page_scheduler_pkg.sv
// Shared constants for the panel double-buffer page scheduler:
// one-hot state encodings and pixel address field widths.
package panel_page_scheduler_pkg;

  localparam int X_W = 6;
  localparam int Y_W = 6;

  localparam logic [2:0] ST_IDLE    = 3'b001;
  localparam logic [2:0] ST_PENDING = 3'b010;
  localparam logic [2:0] ST_CLEAR   = 3'b100;

endpackage

// File: rtl/panel_page_clear.sv
// Back-page clear sweep counter: start launches a pass over every pixel address,
// done marks the final address of the pass.
module panel_page_clear #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ptr,
  output logic              done
);

  logic active;

  assign done = active && (ptr == '1);

  always_ff @(posedge clock) begin
    if (reset) begin
      active <= 1'b0;
      ptr    <= '0;
    end else if (start) begin
      active <= 1'b1;
      ptr    <= '0;
    end else if (active) begin
      // ptr wraps back to zero on the final increment
      ptr <= ptr + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/panel_page_scheduler.sv
// Double-buffer page controller: writes land in the back page, commits swap
// pages at the next scanner frame start, and the new back page is optionally cleared.
module panel_page_scheduler
  import panel_page_scheduler_pkg::*;
#(
  parameter int NUM_PANELS    = 8,
  parameter int ADDR_W        = X_W + Y_W,
  parameter int DATA_W        = 24,
  parameter int CLEAR_ON_SWAP = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_PANELS-1:0] in_en,
  input  logic [15:0]           in_addr,
  input  logic [DATA_W-1:0]     in_wdat,
  input  logic                  commit,
  input  logic                  clear_req,
  input  logic                  frame_start,
  output logic [NUM_PANELS-1:0] ram_en,
  output logic [ADDR_W:0]       ram_addr,
  output logic [DATA_W-1:0]     ram_wdat,
  output logic                  disp_page,
  output logic                  busy,
  output logic [15:0]           drop_count,
  output logic [7:0]            swap_count
);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              deferred;
  logic              deferred_nxt;
  logic              clr_start;
  logic              clr_done;
  logic              swap_now;
  logic [ADDR_W-1:0] clr_ptr;
  logic              write_hit;
  logic              unused_addr_hi;

  assign write_hit      = |in_en;
  assign busy           = (state == ST_PENDING) || (state == ST_CLEAR);
  assign unused_addr_hi = ^in_addr[15:ADDR_W];

  panel_page_clear #(
    .ADDR_W(ADDR_W)
  ) u_clear (
    .clock (clock),
    .reset (reset),
    .start (clr_start),
    .ptr   (clr_ptr),
    .done  (clr_done)
  );

  always_comb begin
    state_nxt    = state;
    deferred_nxt = deferred;
    clr_start    = 1'b0;
    swap_now     = 1'b0;
    case (state)
      ST_IDLE: begin
        // a simultaneous commit is remembered and served after the clear
        if (clear_req) begin
          state_nxt    = ST_CLEAR;
          clr_start    = 1'b1;
          deferred_nxt = commit;
        end else if (commit) begin
          state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_start) begin
          swap_now = 1'b1;
          if (CLEAR_ON_SWAP != 0) begin
            state_nxt = ST_CLEAR;
            clr_start = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_CLEAR: begin
        if (commit) deferred_nxt = 1'b1;
        if (clr_done) begin
          deferred_nxt = 1'b0;
          state_nxt    = (deferred || commit) ? ST_PENDING : ST_IDLE;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        deferred_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      deferred <= 1'b0;
    end else begin
      state    <= state_nxt;
      deferred <= deferred_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ram_en   <= '0;
      ram_addr <= '0;
      ram_wdat <= '0;
    end else if (state == ST_CLEAR) begin
      ram_en   <= '1;
      ram_addr <= {~disp_page, clr_ptr};
      ram_wdat <= '0;
    end else if ((state == ST_IDLE) && write_hit) begin
      ram_en   <= in_en;
      ram_addr <= {~disp_page, in_addr[ADDR_W-1:0]};
      ram_wdat <= in_wdat;
    end else begin
      ram_en <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      disp_page  <= 1'b0;
      swap_count <= '0;
      drop_count <= '0;
    end else begin
      if (swap_now) begin
        disp_page  <= ~disp_page;
        swap_count <= swap_count + 8'd1;
      end
      if (busy && write_hit && (drop_count != '1)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_panel_page_scheduler.sv
// Scoreboard bench for panel_page_scheduler: expected RAM writes are queued as
// stimulus is driven and popped whenever the DUT presents a write.
module tb_panel_page_scheduler;

  localparam int NP = 8;
  localparam int AW = 12;
  localparam int DW = 24;
  localparam int NPIX = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NP-1:0] in_en = '0;
  logic [15:0]   in_addr = '0;
  logic [DW-1:0] in_wdat = '0;
  logic          commit = 1'b0;
  logic          clear_req = 1'b0;
  logic          frame_start = 1'b0;
  logic [NP-1:0] ram_en;
  logic [AW:0]   ram_addr;
  logic [DW-1:0] ram_wdat;
  logic          disp_page;
  logic          busy;
  logic [15:0]   drop_count;
  logic [7:0]    swap_count;

  int total = 0;
  int bad = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_bus;
  logic        exp_disp = 1'b0;

  panel_page_scheduler #(
    .NUM_PANELS(NP),
    .ADDR_W(AW),
    .DATA_W(DW),
    .CLEAR_ON_SWAP(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_en(in_en),
    .in_addr(in_addr),
    .in_wdat(in_wdat),
    .commit(commit),
    .clear_req(clear_req),
    .frame_start(frame_start),
    .ram_en(ram_en),
    .ram_addr(ram_addr),
    .ram_wdat(ram_wdat),
    .disp_page(disp_page),
    .busy(busy),
    .drop_count(drop_count),
    .swap_count(swap_count)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_bus(input logic [NP-1:0] en, input logic [AW:0] a,
                                           input logic [DW-1:0] d);
    return {19'd0, en, a, d};
  endfunction

  always @(negedge clock) begin
    if (ram_en != '0) begin
      if (sb.size() == 0) begin
        check_val("unexpected_write", pack_bus(ram_en, ram_addr, ram_wdat), 64'd0);
      end else begin
        exp_bus = sb.pop_front();
        check_val("ram_bus", pack_bus(ram_en, ram_addr, ram_wdat), exp_bus);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [NP-1:0] en, input logic [15:0] a,
                          input logic [DW-1:0] d, input bit accept);
    in_en   = en;
    in_addr = a;
    in_wdat = d;
    if (accept) sb.push_back(pack_bus(en, {~exp_disp, a[AW-1:0]}, d));
    tick();
    in_en = '0;
  endtask

  task automatic push_clear(input logic page);
    for (int i = 0; i < NPIX; i++) sb.push_back(pack_bus('1, {page, AW'(i)}, '0));
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(negedge clock);
      #1;
      n++;
    end
    check_val("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    reset = 1'b0;
    check_val("rst_ram_en", 64'(ram_en), 64'd0);
    check_val("rst_ram_addr", 64'(ram_addr), 64'd0);
    check_val("rst_disp", 64'(disp_page), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_drop", 64'(drop_count), 64'd0);
    check_val("rst_swap", 64'(swap_count), 64'd0);

    // basic write into back page 1
    do_write(8'h01, 16'h0041, 24'h00ABCD, 1'b1);
    tick();
    check_val("t1_disp", 64'(disp_page), 64'd0);

    // commit, dropped writes, swap on frame_start
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check_val("t2_busy", 64'(busy), 64'd1);
    do_write(8'h01, 16'h0001, 24'h111111, 1'b0);
    do_write(8'h0F, 16'h0002, 24'h222222, 1'b0);
    do_write(8'hF0, 16'h0003, 24'h333333, 1'b0);
    check_val("t2_drop", 64'(drop_count), 64'd3);
    check_val("t2_pre_disp", 64'(disp_page), 64'd0);
    frame_start = 1'b1;
    exp_disp = ~exp_disp;
    push_clear(~exp_disp);
    tick();
    frame_start = 1'b0;
    check_val("t2_disp", 64'(disp_page), 64'(exp_disp));
    check_val("t2_swap", 64'(swap_count), 64'd1);
    check_val("t2_busy_clr", 64'(busy), 64'd1);

    // clear sweep of page 0, then write lands on page 0
    wait_drain(NPIX + 100);
    check_val("t3_busy_end", 64'(busy), 64'd0);
    tick();
    check_val("t3_en_off", 64'(ram_en), 64'd0);
    do_write(8'h80, 16'h0FFF, 24'h123456, 1'b1);
    tick();

    // frame_start alone in IDLE does nothing
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    check_val("fs_idle_disp", 64'(disp_page), 64'(exp_disp));
    check_val("fs_idle_busy", 64'(busy), 64'd0);

    // commit with frame_start in the same cycle defers the swap
    commit = 1'b1;
    frame_start = 1'b1;
    tick();
    commit = 1'b0;
    frame_start = 1'b0;
    check_val("t4_busy", 64'(busy), 64'd1);
    repeat (99) tick();
    check_val("t4_hold_disp", 64'(disp_page), 64'(exp_disp));
    check_val("t4_hold_swap", 64'(swap_count), 64'd1);
    frame_start = 1'b1;
    exp_disp = ~exp_disp;
    push_clear(~exp_disp);
    tick();
    frame_start = 1'b0;
    check_val("t4_disp", 64'(disp_page), 64'(exp_disp));
    check_val("t4_swap", 64'(swap_count), 64'd2);
    wait_drain(NPIX + 100);
    check_val("t4_busy_end", 64'(busy), 64'd0);

    // clear_req with a commit mid-sweep ends in PENDING
    clear_req = 1'b1;
    push_clear(~exp_disp);
    tick();
    clear_req = 1'b0;
    check_val("t5_busy", 64'(busy), 64'd1);
    repeat (9) tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    do_write(8'h02, 16'h0010, 24'h0BAD00, 1'b0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_drain(NPIX + 100);
    check_val("t5_pending", 64'(busy), 64'd1);
    repeat (5) tick();
    check_val("t5_pend_busy", 64'(busy), 64'd1);
    check_val("t5_pend_en", 64'(ram_en), 64'd0);
    frame_start = 1'b1;
    exp_disp = ~exp_disp;
    push_clear(~exp_disp);
    tick();
    frame_start = 1'b0;
    check_val("t5_disp", 64'(disp_page), 64'(exp_disp));
    check_val("t5_swap", 64'(swap_count), 64'd3);
    wait_drain(NPIX + 100);
    check_val("t5_drop", 64'(drop_count), 64'd4);

    // reset in the middle of a sweep
    clear_req = 1'b1;
    push_clear(~exp_disp);
    tick();
    clear_req = 1'b0;
    n = 0;
    while (sb.size() > NPIX - 2000 && n < 3000) begin
      @(negedge clock);
      #1;
      n++;
    end
    check_val("t6_mid", 64'(sb.size()), 64'(NPIX - 2000));
    reset = 1'b1;
    tick();
    sb.delete();
    reset = 1'b0;
    exp_disp = 1'b0;
    check_val("t6_en", 64'(ram_en), 64'd0);
    check_val("t6_disp", 64'(disp_page), 64'd0);
    check_val("t6_busy", 64'(busy), 64'd0);
    check_val("t6_drop", 64'(drop_count), 64'd0);
    check_val("t6_swap", 64'(swap_count), 64'd0);
    do_write(8'h04, 16'hF123, 24'hCAFE01, 1'b1);
    repeat (3) tick();
    check_val("t6_quiet", 64'(ram_en), 64'd0);
    check_val("final_sb", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
